// File: rtl/wb_regfile_if.sv
// wb_regfile_if: WB-stage write bus, ID read ports and retire counter of wb_regfile.
//   master: drives the WB-stage signals and read addresses, sees the read data and counter.
//   slave : the register file side.
interface wb_regfile_if #(parameter int CNT_W = 64);
   logic [4:0]       wb_rd;
   logic [1:0]       wb_control;
   logic [31:0]      wb_result;
   logic [31:0]      wb_read_data;
   logic             wb_valid;
   logic [4:0]       rs1_addr;
   logic [4:0]       rs2_addr;
   logic [31:0]      rs1_data;
   logic [31:0]      rs2_data;
   logic [31:0]      wb_write_data;
   logic             wb_we;
   logic [CNT_W-1:0] retire_count;
   modport master (
      output wb_rd, wb_control, wb_result, wb_read_data, wb_valid, rs1_addr, rs2_addr,
      input  rs1_data, rs2_data, wb_write_data, wb_we, retire_count
   );
   modport slave (
      input  wb_rd, wb_control, wb_result, wb_read_data, wb_valid, rs1_addr, rs2_addr,
      output rs1_data, rs2_data, wb_write_data, wb_we, retire_count
   );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback select, 32x32 register file with write-through read ports, retire counter.
//   clk   : pipeline clock
//   reset : asynchronous active-high reset (x2 <= SP_RESET, everything else 0)
//   bus   : wb_regfile_if slave (WB-stage inputs, two read ports, wb_write_data/wb_we, retire_count)
module wb_regfile #(
   parameter logic [31:0] SP_RESET = 32'h0000_0000,
   parameter int          CNT_W    = 64
) (
   input  logic        clk,
   input  logic        reset,
   wb_regfile_if.slave bus
);
   logic [31:0]      regs [32];
   logic [CNT_W-1:0] cnt;
   assign bus.wb_write_data = bus.wb_control[0] ? bus.wb_read_data : bus.wb_result;
   assign bus.wb_we         = bus.wb_control[1] && (bus.wb_rd != 5'd0);
   // write-first bypass so ID sees the value committing this cycle
   assign bus.rs1_data = (bus.rs1_addr == 5'd0) ? 32'd0 :
                         (bus.wb_we && bus.rs1_addr == bus.wb_rd) ? bus.wb_write_data : regs[bus.rs1_addr];
   assign bus.rs2_data = (bus.rs2_addr == 5'd0) ? 32'd0 :
                         (bus.wb_we && bus.rs2_addr == bus.wb_rd) ? bus.wb_write_data : regs[bus.rs2_addr];
   assign bus.retire_count = cnt;
   // entry 0 is never written (wb_we excludes rd 0) and never read (address 0 forced to 0)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) regs[i] <= (i == 2) ? SP_RESET : 32'd0;
      end else if (bus.wb_we) begin
         regs[bus.wb_rd] <= bus.wb_write_data;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) cnt <= '0;
      else if (bus.wb_valid) cnt <= cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed test of wb_regfile against an array model, with literal spot checks.
module tb_wb_regfile;
   localparam logic [31:0] SP = 32'h0000_8000;
   localparam int          CW = 4;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad = 0;
   bit   en = 1'b0;
   wb_regfile_if #(.CNT_W(CW)) bus ();
   wb_regfile #(.SP_RESET(SP), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   logic [31:0] m [32];
   int          mcnt;
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
      end
   endtask
   function automatic logic [31:0] sel();
      return bus.wb_control[0] ? bus.wb_read_data : bus.wb_result;
   endfunction
   function automatic bit we();
      return bus.wb_control[1] && bus.wb_rd != 0;
   endfunction
   function automatic logic [31:0] rd_exp(input logic [4:0] a);
      if (a == 0) return 32'd0;
      if (we() && a == bus.wb_rd) return sel();
      return m[a];
   endfunction
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) m[i] <= (i == 2) ? SP : 32'd0;
         mcnt <= 0;
      end else begin
         if (we()) m[bus.wb_rd] <= sel();
         if (bus.wb_valid) mcnt <= (mcnt + 1) % (1 << CW);
      end
   end
   always @(negedge clk) begin
      if (en) begin
         chk("m_wdata", 64'(bus.wb_write_data), 64'(sel()));
         chk("m_we", 64'(bus.wb_we), 64'(we()));
         chk("m_rs1", 64'(bus.rs1_data), 64'(rd_exp(bus.rs1_addr)));
         chk("m_rs2", 64'(bus.rs2_data), 64'(rd_exp(bus.rs2_addr)));
         chk("m_cnt", 64'(bus.retire_count), 64'(mcnt));
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.wb_rd = 0; bus.wb_control = 0; bus.wb_result = 0; bus.wb_read_data = 0;
      bus.wb_valid = 0; bus.rs1_addr = 2; bus.rs2_addr = 5;
      #2 reset = 1'b1;
      #1;
      chk("rst_sp", 64'(bus.rs1_data), 64'h8000);
      chk("rst_x5", 64'(bus.rs2_data), 64'h0);
      chk("rst_cnt", 64'(bus.retire_count), 64'h0);
      en = 1'b1;
      step();
      reset = 1'b0;
      step();
      bus.wb_rd = 7; bus.wb_control = 2'b10; bus.wb_result = 32'hDEAD_BEEF; bus.wb_valid = 1; bus.rs1_addr = 7;
      #1;
      chk("alu_bypass", 64'(bus.rs1_data), 64'hDEAD_BEEF);
      chk("alu_we", 64'(bus.wb_we), 64'h1);
      step();
      bus.wb_control = 0; bus.wb_valid = 0;
      #1;
      chk("alu_stored", 64'(bus.rs1_data), 64'hDEAD_BEEF);
      chk("alu_cnt", 64'(bus.retire_count), 64'h1);
      bus.wb_control = 2'b11; bus.wb_rd = 9; bus.wb_result = 1; bus.wb_read_data = 32'hFFFF_FF80; bus.wb_valid = 1;
      #1;
      chk("ld_wdata", 64'(bus.wb_write_data), 64'hFFFF_FF80);
      step();
      bus.wb_control = 0; bus.wb_valid = 0; bus.rs2_addr = 9;
      #1;
      chk("ld_x9", 64'(bus.rs2_data), 64'hFFFF_FF80);
      bus.wb_rd = 0; bus.wb_control = 2'b10; bus.wb_result = 5; bus.wb_valid = 1; bus.rs1_addr = 0; bus.rs2_addr = 0;
      #1;
      chk("x0_we", 64'(bus.wb_we), 64'h0);
      chk("x0_rs1", 64'(bus.rs1_data), 64'h0);
      chk("x0_rs2", 64'(bus.rs2_data), 64'h0);
      step();
      bus.wb_valid = 0;
      #1;
      chk("x0_rs1_next", 64'(bus.rs1_data), 64'h0);
      chk("x0_rs2_next", 64'(bus.rs2_data), 64'h0);
      chk("x0_cnt", 64'(bus.retire_count), 64'h3);
      bus.wb_rd = 4; bus.wb_control = 2'b10; bus.wb_result = 32'h1234_5678; bus.wb_valid = 1; bus.rs1_addr = 4;
      step();
      bus.wb_valid = 0;
      step();
      step();
      bus.wb_control = 0;
      #1;
      chk("held_x4", 64'(bus.rs1_data), 64'h1234_5678);
      chk("held_cnt", 64'(bus.retire_count), 64'h4);
      bus.wb_valid = 1;
      for (int i = 0; i < 12; i++) step();
      bus.wb_valid = 0;
      #1;
      chk("wrap_to0", 64'(bus.retire_count), 64'h0);
      bus.wb_valid = 1;
      for (int i = 0; i < 16; i++) step();
      bus.wb_valid = 0;
      #1;
      chk("wrap16", 64'(bus.retire_count), 64'h0);
      bus.wb_valid = 1;
      step();
      bus.wb_valid = 0;
      #1;
      chk("cnt_one", 64'(bus.retire_count), 64'h1);
      bus.wb_rd = 10; bus.wb_control = 2'b10; bus.wb_result = 32'hAAAA_5555; bus.wb_valid = 1;
      bus.rs1_addr = 10; bus.rs2_addr = 2;
      #2 reset = 1'b1;
      step();
      bus.wb_control = 0; bus.wb_valid = 0;
      #1 reset = 1'b0;
      #1;
      chk("rst_x10", 64'(bus.rs1_data), 64'h0);
      chk("rst_sp2", 64'(bus.rs2_data), 64'h8000);
      chk("rst_cnt2", 64'(bus.retire_count), 64'h0);
      step();
      chk("rst_x10_next", 64'(bus.rs1_data), 64'h0);
      step();
      en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
